// File: rtl/branch_recover_unit.sv
// In-order tracker for predicted conditional branches: detects mispredicts at resolve,
// issues a one-cycle redirect and holds a flush window. Optional counters via BRU_STATS_EN.
module branch_recover_unit #(
  parameter int DEPTH        = 4,
  parameter int PTR_W        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  input  logic             alloc_pred_taken,
  input  logic [31:0]      alloc_target_pc,
  input  logic [31:0]      alloc_fall_pc,
  output logic             alloc_ready,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             recover_en,
  output logic [31:0]      recover_pc,
  output logic             flush,
  output logic [PTR_W:0]   inflight_cnt,
  output logic             resolve_err
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispred_cnt
`endif
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t             state_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic [CNT_W-1:0]   flush_cnt_reg;
  logic               recover_en_reg;
  logic [31:0]        recover_pc_reg;
  logic               flush_reg;
  logic               resolve_err_reg;

  logic               pred_mem   [DEPTH];
  logic [31:0]        target_mem [DEPTH];
  logic [31:0]        fall_mem   [DEPTH];

  logic               head_pred;
  logic [31:0]        head_target;
  logic [31:0]        head_fall;
  logic               push;
  logic               pop;
  logic               mispredict;

  assign alloc_ready = (state_reg == IDLE) && (count_reg < FULL_CNT);
  assign push        = alloc_valid && alloc_ready;
  assign pop         = (state_reg == IDLE) && resolve_valid && (count_reg != '0);

  assign head_pred   = pred_mem[rd_ptr_reg];
  assign head_target = target_mem[rd_ptr_reg];
  assign head_fall   = fall_mem[rd_ptr_reg];
  assign mispredict  = pop && (resolve_taken != head_pred);

  // An alloc in the mispredict cycle is younger than the bad branch, so it is never stored.
  always_ff @(posedge clk) begin
    if (push && !mispredict) begin
      pred_mem[wr_ptr_reg]   <= alloc_pred_taken;
      target_mem[wr_ptr_reg] <= alloc_target_pc;
      fall_mem[wr_ptr_reg]   <= alloc_fall_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      flush_cnt_reg   <= '0;
      recover_en_reg  <= 1'b0;
      recover_pc_reg  <= '0;
      flush_reg       <= 1'b0;
      resolve_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (resolve_valid && (count_reg == '0))
            resolve_err_reg <= 1'b1;
          if (mispredict) begin
            state_reg      <= REDIRECT;
            recover_en_reg <= 1'b1;
            recover_pc_reg <= resolve_taken ? head_target : head_fall;
            flush_reg      <= 1'b1;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
          end else begin
            if (push)
              wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
              rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
              2'b10:   count_reg <= count_reg + 1'b1;
              2'b01:   count_reg <= count_reg - 1'b1;
              default: count_reg <= count_reg;
            endcase
          end
        end
        REDIRECT: begin
          recover_en_reg <= 1'b0;
          flush_cnt_reg  <= CNT_W'(FLUSH_CYCLES - 1);
          state_reg      <= FLUSH;
        end
        FLUSH: begin
          if (flush_cnt_reg == '0) begin
            state_reg <= IDLE;
            flush_reg <= 1'b0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign recover_en   = recover_en_reg;
  assign recover_pc   = recover_pc_reg;
  assign flush        = flush_reg;
  assign inflight_cnt = count_reg;
  assign resolve_err  = resolve_err_reg;

`ifdef BRU_STATS_EN
  logic [31:0] branch_cnt_reg;
  logic [31:0] mispred_cnt_reg;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_reg  <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      if (pop && (branch_cnt_reg != '1))
        branch_cnt_reg <= branch_cnt_reg + 1'b1;
      if (mispredict && (mispred_cnt_reg != '1))
        mispred_cnt_reg <= mispred_cnt_reg + 1'b1;
    end
  end

  assign branch_cnt  = branch_cnt_reg;
  assign mispred_cnt = mispred_cnt_reg;
`endif

endmodule

// File: tb/tb_branch_recover_unit.sv
// Randomized + directed bench for branch_recover_unit, checked every cycle against a
// queue-based model of the in-flight branches and the recovery window.
module tb_branch_recover_unit;
  localparam int DEPTH = 4;
  localparam int FC    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid, alloc_pred_taken;
  logic [31:0] alloc_target_pc, alloc_fall_pc;
  logic        alloc_ready;
  logic        resolve_valid, resolve_taken;
  logic        recover_en;
  logic [31:0] recover_pc;
  logic        flush;
  logic [2:0]  inflight_cnt;
  logic        resolve_err;
`ifdef BRU_STATS_EN
  logic [31:0] branch_cnt, mispred_cnt;
`endif

  branch_recover_unit #(.DEPTH(DEPTH), .PTR_W(2), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_pred_taken(alloc_pred_taken),
    .alloc_target_pc(alloc_target_pc), .alloc_fall_pc(alloc_fall_pc),
    .alloc_ready(alloc_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .recover_en(recover_en), .recover_pc(recover_pc), .flush(flush),
    .inflight_cnt(inflight_cnt), .resolve_err(resolve_err)
`ifdef BRU_STATS_EN
    , .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        p;
    logic [31:0] t;
    logic [31:0] f;
  } rec_t;

  rec_t        q[$];
  int          m_busy;   // remaining cycles of redirect+flush; 0 means accepting work
  logic        m_ren, m_flush, m_err;
  logic [31:0] m_rpc;
  int          m_bc, m_mc;
  int          n_vec = 0;
  int          n_err = 0;
  bit          chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return (m_busy == 0) && (q.size() < DEPTH);
  endfunction

  // Reference model: branch queue plus a countdown for the recovery window.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_busy = 0; m_ren = 0; m_rpc = 0; m_flush = 0; m_err = 0; m_bc = 0; m_mc = 0;
    end else if (m_busy != 0) begin
      m_ren = 0;
      m_busy--;
      m_flush = (m_busy != 0);
    end else begin
      bit   acc;
      rec_t h;
      m_ren = 0;
      acc = alloc_valid && (q.size() < DEPTH);
      if (resolve_valid && q.size() == 0) begin
        m_err = 1;
      end else if (resolve_valid) begin
        h = q.pop_front();
        m_bc++;
        if (resolve_taken != h.p) begin
          m_mc++;
          m_ren = 1;
          m_rpc = resolve_taken ? h.t : h.f;
          q.delete();
          m_busy = 1 + FC;
          m_flush = 1;
          acc = 0;
        end
      end
      if (acc) q.push_back('{p: alloc_pred_taken, t: alloc_target_pc, f: alloc_fall_pc});
    end
  end

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      chk("alloc_ready", {31'd0, alloc_ready}, {31'd0, m_ready()});
      chk("recover_en", {31'd0, recover_en}, {31'd0, m_ren});
      chk("recover_pc", recover_pc, m_rpc);
      chk("flush", {31'd0, flush}, {31'd0, m_flush});
      chk("inflight_cnt", {29'd0, inflight_cnt}, q.size());
      chk("resolve_err", {31'd0, resolve_err}, {31'd0, m_err});
`ifdef BRU_STATS_EN
      chk("branch_cnt", branch_cnt, m_bc);
      chk("mispred_cnt", mispred_cnt, m_mc);
`endif
    end
  end

  task automatic cyc(input logic av, input logic ap, input logic [31:0] tp, input logic [31:0] fp,
                     input logic rv, input logic rt);
    alloc_valid = av; alloc_pred_taken = ap; alloc_target_pc = tp; alloc_fall_pc = fp;
    resolve_valid = rv; resolve_taken = rt;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, alloc_ready}, 32'd1);
    chk({tag, "_ren"}, {31'd0, recover_en}, 32'd0);
    chk({tag, "_rpc"}, recover_pc, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_cnt"}, {29'd0, inflight_cnt}, 32'd0);
    chk({tag, "_err"}, {31'd0, resolve_err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    chk_on = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);

    // Fill the queue, then a fifth alloc is dropped.
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 32'h80000000 + 32'(16 * (i + 1)), 32'h80000104 + 32'(16 * i), 0, 0);
    chk("full_ready", {31'd0, alloc_ready}, 32'd0);
    chk("full_cnt", {29'd0, inflight_cnt}, 32'd4);
    cyc(1, 1, 32'h80000050, 32'h80000154, 0, 0);
    chk("drop5_cnt", {29'd0, inflight_cnt}, 32'd4);

    // Full + same-cycle correct resolve: alloc rejected, count drops.
    cyc(1, 1, 32'h80000060, 32'h80000164, 1, 1);
    chk("fullres_cnt", {29'd0, inflight_cnt}, 32'd3);
    cyc(1, 1, 32'h80000070, 32'h80000174, 0, 0);
    chk("refill_cnt", {29'd0, inflight_cnt}, 32'd4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 1);
    chk("drain_cnt", {29'd0, inflight_cnt}, 32'd0);

    // Mispredict (pred not-taken, actually taken) with a concurrent alloc.
    cyc(1, 0, 32'h80000200, 32'h80000104, 0, 0);
    cyc(1, 1, 32'h80000300, 32'h80000304, 1, 1);
    chk("mp_ren", {31'd0, recover_en}, 32'd1);
    chk("mp_rpc", recover_pc, 32'h80000200);
    chk("mp_flush", {31'd0, flush}, 32'd1);
    chk("mp_cnt", {29'd0, inflight_cnt}, 32'd0);
    chk("mp_ready", {31'd0, alloc_ready}, 32'd0);
    cyc(1, 1, 32'h80000400, 32'h80000404, 1, 0);
    chk("fl1_flush", {31'd0, flush}, 32'd1);
    chk("fl1_ren", {31'd0, recover_en}, 32'd0);
    cyc(1, 0, 32'h80000500, 32'h80000504, 1, 1);
    chk("fl2_flush", {31'd0, flush}, 32'd1);
    chk("fl2_cnt", {29'd0, inflight_cnt}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("idle_flush", {31'd0, flush}, 32'd0);
    chk("idle_ready", {31'd0, alloc_ready}, 32'd1);
    chk("idle_cnt", {29'd0, inflight_cnt}, 32'd0);
    chk("hold_rpc", recover_pc, 32'h80000200);

    // Resolve on empty queue sets the sticky error.
    cyc(0, 0, 0, 0, 1, 0);
    chk("err_set", {31'd0, resolve_err}, 32'd1);
    chk("err_ren", {31'd0, recover_en}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("err_sticky", {31'd0, resolve_err}, 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) < 60, 1'($urandom), $urandom, $urandom,
          $urandom_range(0, 99) < 40, 1'($urandom));

    // Force a mispredict, then assert async reset during FLUSH.
    for (int i = 0; i < 10 && m_busy != 0; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("pre_rst_idle", m_busy, 32'd0);
    cyc(1, 1, 32'h80000600, 32'h80000604, 0, 0);
    if (q.size() > 0) cyc(0, 0, 0, 0, 1, ~q[0].p);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
